// File: rtl/line_pixel_streamer.sv
// Line pixel streamer: buffers packed 4-pixel words in a small FIFO and emits
// one line of pixels on an AXI-Stream style output, pixel 0 from the low byte.
module line_pixel_streamer #(
    parameter int WORD_W     = 32,
    parameter int PIX_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 12
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [WORD_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          start,
    input  logic [LEN_W-1:0]              line_len,
    output logic [PIX_W-1:0]              m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          busy,
    output logic                          line_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              in_ready_q, in_ready_d;
    logic              push_s, pop_s, empty_s;
    logic [WORD_W-1:0] rdata_s;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [PIX_W-1:0]  tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic              busy_q, busy_d, done_q, done_d;

    // FIFO pointer and occupancy update; in_ready is registered from the next level
    always_comb begin
        push_s  = in_valid && in_ready_q;
        empty_s = (level_q == {(AW+1){1'b0}});
        rdata_s = mem[rd_ptr_q];
        if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
        else        wr_ptr_d = wr_ptr_q;
        if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
        else        rd_ptr_d = rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        in_ready_d = (level_d != FULL_LVL);
    end

    // FIFO storage, written on accepted input words
    always_ff @(posedge ACLK) begin
        if (push_s) mem[wr_ptr_q] <= in_data;
    end

    // Line FSM next-state, datapath and next output values
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sreg_d  = sreg_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = line_len;
                    cnt_d   = {LEN_W{1'b0}};
                    state_d = (line_len == {LEN_W{1'b0}}) ? ST_DONE : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    sreg_d  = rdata_s;
                    idx_d   = 2'd0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                if (m_axis_tready) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    idx_d = idx_q + 2'd1;
                    if (tlast_q) begin
                        state_d = ST_DONE;
                    end else if (idx_q == 2'd3) begin
                        // Chain straight into the next word when one is waiting
                        if (!empty_s) begin
                            pop_s   = 1'b1;
                            sreg_d  = rdata_s;
                            state_d = ST_SHIFT;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        tvalid_d = (state_d == ST_SHIFT);
        tlast_d  = tvalid_d && (cnt_d == (len_d - LEN_W'(1)));
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        if (tvalid_d) begin
            case (idx_d)
                2'd0:    tdata_d = sreg_d[PIX_W-1:0];
                2'd1:    tdata_d = sreg_d[2*PIX_W-1:PIX_W];
                2'd2:    tdata_d = sreg_d[3*PIX_W-1:2*PIX_W];
                2'd3:    tdata_d = sreg_d[4*PIX_W-1:3*PIX_W];
                default: tdata_d = {PIX_W{1'b0}};
            endcase
        end else begin
            tdata_d = {PIX_W{1'b0}};
        end
    end

    // State and output registers, all cleared by the asynchronous reset
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            level_q    <= {(AW+1){1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= ST_IDLE;
            len_q      <= {LEN_W{1'b0}};
            cnt_q      <= {LEN_W{1'b0}};
            idx_q      <= 2'd0;
            sreg_q     <= {WORD_W{1'b0}};
            tdata_q    <= {PIX_W{1'b0}};
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sreg_q     <= sreg_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign line_done     = done_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_line_pixel_streamer.sv
// Scoreboard bench for line_pixel_streamer: expected pixels are queued by the
// stimulus thread and consumed by a negedge monitor on every output handshake.
module tb_line_pixel_streamer;

    localparam int WORD_W     = 32;
    localparam int PIX_W      = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int LEN_W      = 12;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              start;
    logic [LEN_W-1:0]  line_len;
    logic [PIX_W-1:0]  m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              busy;
    logic              line_done;
    logic [3:0]        fifo_level;

    line_pixel_streamer #(
        .WORD_W(WORD_W), .PIX_W(PIX_W), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .line_len(line_len),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .line_done(line_done), .fifo_level(fifo_level)
    );

    always #5 ACLK = ~ACLK;

    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    int         hs_cnt   = 0;
    logic [8:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_pix(input logic [7:0] d, input logic l);
        sb_q.push_back({l, d});
    endtask

    task automatic push_word(input logic [31:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge ACLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic start_line(input logic [LEN_W-1:0] len, output int lat);
        line_len = len;
        start    = 1'b1;
        lat      = 0;
        while (lat < 20) begin
            @(posedge ACLK); #1;
            lat++;
            start = 1'b0;
            if (m_axis_tvalid) break;
        end
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (cyc < max) begin
            @(posedge ACLK); #1;
            cyc++;
            if (line_done) break;
        end
        check("line_done_seen", 32'(line_done), 32'd1);
        @(posedge ACLK); #1;
        check("line_done_pulse", 32'(line_done), 32'd0);
        check("idle_after_line", 32'(busy), 32'd0);
    endtask

    // Monitor: pops expected pixels on handshakes and checks stability while stalled
    initial begin : monitor
        logic       held_v;
        logic [8:0] held;
        logic [8:0] exp;
        held_v = 1'b0;
        held   = 9'd0;
        forever begin
            @(negedge ACLK);
            if (ARESETN) begin
                if (line_done) done_cnt++;
                if (held_v)
                    check("hold_stable", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                          32'({1'b1, held}));
                if (m_axis_tvalid && m_axis_tready) begin
                    hs_cnt++;
                    held_v = 1'b0;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pixel: got 0x%0h, expected none",
                                 {m_axis_tlast, m_axis_tdata});
                    end else begin
                        exp = sb_q.pop_front();
                        check("pixel", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp));
                    end
                end else if (m_axis_tvalid) begin
                    held_v = 1'b1;
                    held   = {m_axis_tlast, m_axis_tdata};
                end else begin
                    held_v = 1'b0;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int         lat, cyc, n, base, dc, pushed;
        logic       seen;
        logic [7:0] b;

        ARESETN = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        start = 1'b0; line_len = 12'd0; m_axis_tready = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_line_done", 32'(line_done), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Full line of 8 with tready held high
        push_word(32'h04030201);
        push_word(32'h08070605);
        check("level_two", 32'(fifo_level), 32'd2);
        for (int i = 1; i <= 8; i++) expect_pix(8'(i), i == 8);
        start_line(12'd8, lat);
        check("start_latency", 32'(lat), 32'd2);
        wait_done(20, cyc);
        check("line8_cycles", 32'(cyc), 32'd8);
        check("sb_drained_8", 32'(sb_q.size()), 32'd0);

        // Short line: rest of the second word is dropped
        push_word(32'h04030201);
        push_word(32'h08070605);
        for (int i = 1; i <= 5; i++) expect_pix(8'(i), i == 5);
        start_line(12'd5, lat);
        check("start_latency_5", 32'(lat), 32'd2);
        wait_done(20, cyc);
        check("line5_cycles", 32'(cyc), 32'd5);
        check("level_after_5", 32'(fifo_level), 32'd0);
        check("sb_drained_5", 32'(sb_q.size()), 32'd0);

        // Fill the FIFO; the ninth word must be refused
        for (int i = 0; i < 9; i++) begin
            b = 8'h20 + 8'(4 * i);
            in_data  = (i < 8) ? {b + 8'd3, b + 8'd2, b + 8'd1, b} : 32'hDEADBEEF;
            in_valid = 1'b1;
            check("in_ready_fill", 32'(in_ready), 32'(i < 8));
            @(posedge ACLK); #1;
        end
        in_valid = 1'b0;
        check("level_full", 32'(fifo_level), 32'd8);
        check("in_ready_full", 32'(in_ready), 32'd0);
        for (int k = 0; k < 32; k++) expect_pix(8'h20 + 8'(k), k == 31);
        start_line(12'd32, lat);
        check("start_latency_32", 32'(lat), 32'd2);
        wait_done(60, cyc);
        check("line32_no_bubble", 32'(cyc), 32'd32);
        check("in_ready_drained", 32'(in_ready), 32'd1);
        check("sb_drained_32", 32'(sb_q.size()), 32'd0);

        // Back-pressure: tready toggles every cycle
        push_word(32'h14131211);
        push_word(32'h18171615);
        for (int i = 1; i <= 8; i++) expect_pix(8'h10 + 8'(i), i == 8);
        start_line(12'd8, lat);
        seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            m_axis_tready = ~m_axis_tready;
            @(posedge ACLK); #1;
            if (line_done) seen = 1'b1;
        end
        m_axis_tready = 1'b1;
        check("toggle_done", 32'(seen), 32'd1);
        check("sb_drained_toggle", 32'(sb_q.size()), 32'd0);
        @(posedge ACLK); #1;

        // Start on empty FIFO, second start while busy must be ignored
        expect_pix(8'h11, 1'b0); expect_pix(8'h22, 1'b0);
        expect_pix(8'h33, 1'b0); expect_pix(8'h44, 1'b1);
        line_len = 12'd4;
        start    = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
        for (int t = 0; t < 10; t++) begin
            check("no_tvalid_empty", 32'(m_axis_tvalid), 32'd0);
            check("busy_waiting", 32'(busy), 32'd1);
            if (t == 4) begin start = 1'b1; line_len = 12'd8; end
            else        start = 1'b0;
            @(posedge ACLK); #1;
        end
        start = 1'b0;
        line_len = 12'd4;
        in_data  = 32'h44332211;
        in_valid = 1'b1;
        lat = 0;
        while (lat < 10) begin
            @(posedge ACLK); #1;
            lat++;
            in_valid = 1'b0;
            if (m_axis_tvalid) break;
        end
        check("push_to_tvalid", 32'(lat), 32'd2);
        wait_done(20, cyc);
        check("line4_cycles", 32'(cyc), 32'd4);
        check("sb_drained_4", 32'(sb_q.size()), 32'd0);

        // Zero-length line goes straight to DONE
        line_len = 12'd0;
        start    = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
        check("len0_done", 32'(line_done), 32'd1);
        check("len0_no_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(posedge ACLK); #1;
        check("len0_pulse", 32'(line_done), 32'd0);
        check("len0_idle", 32'(busy), 32'd0);

        // Reset after 3 of 8 pixels
        push_word(32'h24232221);
        push_word(32'h28272625);
        for (int i = 1; i <= 8; i++) expect_pix(8'h20 + 8'(i), i == 8);
        start_line(12'd8, lat);
        base = hs_cnt;
        n = 0;
        while (hs_cnt < base + 3 && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        check("three_pixels_sent", 32'(hs_cnt - base), 32'd3);
        dc = done_cnt;
        ARESETN = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("no_done_after_rst", 32'(done_cnt - dc), 32'd0);
        check("post_rst_level", 32'(fifo_level), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        push_word(32'h64636261);
        push_word(32'h68676665);
        for (int i = 1; i <= 6; i++) expect_pix(8'h60 + 8'(i), i == 6);
        start_line(12'd6, lat);
        check("post_rst_latency", 32'(lat), 32'd2);
        wait_done(20, cyc);
        check("line6_cycles", 32'(cyc), 32'd6);
        check("level_after_6", 32'(fifo_level), 32'd0);
        check("sb_drained_6", 32'(sb_q.size()), 32'd0);

        // Maximum line length with concurrent feeding
        for (int k = 0; k < 4095; k++) expect_pix(8'(k), k == 4094);
        line_len = 12'd4095;
        start    = 1'b1;
        pushed   = 0;
        n        = 0;
        seen     = 1'b0;
        while (n < 6000 && !seen) begin
            in_valid = (pushed < 1024);
            in_data  = {8'(4 * pushed + 3), 8'(4 * pushed + 2), 8'(4 * pushed + 1), 8'(4 * pushed)};
            if (in_valid && in_ready) pushed++;
            @(posedge ACLK); #1;
            start = 1'b0;
            n++;
            if (line_done) seen = 1'b1;
        end
        in_valid = 1'b0;
        check("len4095_done", 32'(seen), 32'd1);
        check("len4095_words", 32'(pushed), 32'd1024);
        check("len4095_level", 32'(fifo_level), 32'd0);
        check("sb_drained_4095", 32'(sb_q.size()), 32'd0);
        @(posedge ACLK); #1;
        check("len4095_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_pixel_streamer.md
LINE_PIXEL_STREAMER -- requirements
Module: line_pixel_streamer

Interface
REQ-001 SHALL have parameter WORD_W, default 32: width of input word; fixed at 4 pixels of PIX_W.
REQ-002 SHALL have parameter PIX_W, default 8: output pixel width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: input word FIFO depth, power of 2.
REQ-004 SHALL have parameter LEN_W, default 12: width of the line length field.
REQ-005 ACLK  input  1  sole clock, all logic rising-edge.
REQ-006 ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-007 in_data  input  WORD_W  packed pixel word from send_line_data; pixel 0 in bits [7:0].
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  FIFO can accept; equals not-full.
REQ-010 start  input  1  one-cycle pulse requesting one line.
REQ-011 line_len  input  LEN_W  pixels in the line; sampled on accepted start.
REQ-012 m_axis_tdata  output  PIX_W  pixel out.
REQ-013 m_axis_tvalid  output  1  pixel valid.
REQ-014 m_axis_tready  input  1  downstream accept.
REQ-015 m_axis_tlast  output  1  high on last pixel of line.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 line_done  output  1  one-cycle pulse at end of line.
REQ-018 fifo_level  output  log2(FIFO_DEPTH)+1  current word count.

Function
REQ-019 Push SHALL occur when in_valid && in_ready; in_ready SHALL depend only on current full flag, not on a same-cycle pop.
REQ-020 Simultaneous push and pop SHALL leave fifo_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-022 IDLE: on start, latch line_len, clear pixel count; line_len==0 -> DONE, else -> LOAD.
REQ-023 start SHALL be ignored when busy=1.
REQ-024 LOAD: if FIFO non-empty, pop word into shift register, byte index=0, -> SHIFT next cycle; else stay in LOAD, tvalid=0.
REQ-025 SHIFT: tvalid=1, tdata=byte[index]; tdata/tlast SHALL remain stable until tvalid && tready.
REQ-026 On each SHIFT handshake, pixel count and byte index SHALL increment.
REQ-027 tlast SHALL be 1 exactly when pixel count == latched line_len-1; after that handshake -> DONE; unsent bytes of that word SHALL be discarded.
REQ-028 Handshake at index 3 (not last): if FIFO non-empty, pop next word and stay in SHIFT with no bubble; else -> LOAD.
REQ-029 DONE: line_done=1 for exactly one cycle, -> IDLE.
REQ-030 Minimum latency start -> first tvalid SHALL be 2 cycles when FIFO non-empty (IDLE->LOAD->SHIFT).
REQ-031 line_len=4095 SHALL be supported without counter overflow.

Reset
REQ-032 ARESETN low SHALL asynchronously force IDLE, FIFO empty, fifo_level=0, tvalid=0, tlast=0, tdata=0, busy=0, line_done=0.
REQ-033 in_ready SHALL be 0 while ARESETN low and 1 from the first cycle after release.
REQ-034 Reset mid-line SHALL discard the line and FIFO contents; no line_done.

Verification
REQ-035 Push 0x04030201, 0x08070605; start with line_len=8, tready=1 -> tdata 01..08 on consecutive cycles, tlast on 08, line_done one cycle later.
REQ-036 line_len=5, words as above -> 01..05, tlast on 05; 06..08 discarded; fifo_level=0 after.
REQ-037 Push 9 words without popping -> in_ready=0 after 8th, 9th not accepted, fifo_level=8.
REQ-038 tready toggled 1/0 every cycle during line of 8 -> each pixel held stable while tready=0; order unchanged.
REQ-039 start with empty FIFO, push word 10 cycles later -> tvalid=0 until 2 cycles after push, then pixels; start pulse while busy ignored.
REQ-040 ARESETN low for 1 cycle after 3 pixels of 8 -> all outputs 0, fifo_level=0, no line_done; new line runs normally after release.
